// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding plus line constants
// used by both the result transmitter and the load-path receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int         CLKS_PER_BIT_DEFAULT = 434;
    localparam logic [7:0] EOT_BYTE_DEFAULT     = 8'h04;

endpackage

// File: rtl/uart_result_tx_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout shows the head word
// combinationally whenever the FIFO is not empty.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_result_tx.sv
// 8N1 transmitter for 16-bit writeback results (high byte first), with a
// trailing EOT byte once the program signals done and the FIFO drains.
module uart_result_tx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] EOT_BYTE     = EOT_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        result_valid,
    input  logic [15:0] result_data,
    input  logic        done,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic [1:0]  fsm_state
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t state, state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [15:0]   shift_reg;
    logic          byte_hi;
    logic          eot_pending;
    logic          baud_last;
    logic          pop;
    logic          load_word;
    logic          load_eot;
    logic          next_byte;
    logic          fifo_empty;
    logic          push_ok;
    logic [15:0]   fifo_dout;
    logic [7:0]    cur_byte;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign push_ok   = result_valid && (!fifo_full || pop);
    assign cur_byte  = shift_reg[15:8];
    assign fsm_state = state;

    sync_fifo #(
        .DATA_W(16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push_ok),
        .pop  (pop),
        .din  (result_data),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_word  = 1'b0;
        load_eot   = 1'b0;
        next_byte  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Queued words always go before the EOT byte.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load_word  = 1'b1;
                    state_next = ST_START;
                end else if (eot_pending) begin
                    load_eot   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: if (baud_last) state_next = ST_DATA;
            ST_DATA:  if (baud_last && bit_idx == 3'd7) state_next = ST_STOP;
            ST_STOP: begin
                if (baud_last) begin
                    if (byte_hi) begin
                        next_byte  = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            byte_hi     <= 1'b0;
            eot_pending <= 1'b0;
            overflow    <= 1'b0;
            tx          <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state <= state_next;

            if (state == ST_IDLE || state_next != state || baud_last) baud_cnt <= '0;
            else                                                     baud_cnt <= baud_cnt + BW'(1);

            if (state_next != state)             bit_idx <= '0;
            else if (state == ST_DATA && baud_last) bit_idx <= bit_idx + 3'd1;

            if (load_word) begin
                shift_reg <= fifo_dout;
                byte_hi   <= 1'b1;
            end else if (load_eot) begin
                shift_reg <= {EOT_BYTE, 8'h00};
                byte_hi   <= 1'b0;
            end else if (next_byte) begin
                shift_reg <= {shift_reg[7:0], 8'h00};
                byte_hi   <= 1'b0;
            end

            // A done that lands while EOT is already pending is absorbed.
            if (load_eot)  eot_pending <= 1'b0;
            else if (done) eot_pending <= 1'b1;

            if (result_valid && fifo_full && !pop) overflow <= 1'b1;

            case (state)
                ST_START: tx <= 1'b0;
                ST_DATA:  tx <= cur_byte[bit_idx];
                default:  tx <= 1'b1;
            endcase

            busy <= (state != ST_IDLE) || !fifo_empty || eot_pending;
        end
    end

endmodule
